fc_chain_sequencer: RTL and testbench

- Parametrised control sequencer for the fully-connected back end of the CNN.
- Drives weight-memory addressing, per-layer reset release, activation-unit start and classifier enable for a chain of NUM_STAGES dense layers.
- Replaces fixed cycle-count scheduling with a start/busy/done handshake and done-driven stage transitions.
- Sits between the conv/pool integration and the dense layer/weightMemory/activation/softmax instances.

---
 rtl/fc_chain_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fc_chain_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_chain_sequencer.sv
// Start/busy/done sequencer for the dense-layer chain: weight addressing, per-stage reset release,
// activation and classifier hand-off. Define FC_SEQ_TIMEOUT_EN to enable the ACT/CLS watchdog (err).
module fc_chain_sequencer #(
    parameter int                     NUM_STAGES = 2,
    parameter int                     ADDR_W     = 8,
    parameter logic [16*NUM_STAGES-1:0] STAGE_IN = {16'd84, 16'd120},
    parameter int                     TAIL_CYC   = 10,
    parameter int                     TMO_CYC    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            stage_idx,
    output logic [ADDR_W-1:0]     w_addr,
    output logic [NUM_STAGES-1:0] w_sel,
    output logic [NUM_STAGES-1:0] layer_rst,
    output logic [NUM_STAGES-1:0] act_rst,
    input  logic [NUM_STAGES-1:0] act_done,
    output logic                  cls_en,
    input  logic                  cls_ack,
    output logic                  err
);
    // state   | meaning
    // S_IDLE  | outputs at reset values, waiting for start
    // S_LAYER | streaming weight addresses of stage stage_idx, then TAIL_CYC drain cycles
    // S_ACT   | activation of stage stage_idx released, waiting for its act_done
    // S_CLS   | classifier enabled, waiting for cls_ack
    // S_FIN   | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_LAYER, S_ACT, S_CLS, S_FIN} state_t;

    localparam int LAYER_MAX = (1 << ADDR_W) + TAIL_CYC;
    localparam int CNT_MAX   = (LAYER_MAX > TMO_CYC) ? LAYER_MAX : TMO_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYC - 1);
    localparam logic [1:0] LAST = 2'(NUM_STAGES - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  firstCyc;
    logic [15:0]           stageIn [4];
    logic [NUM_STAGES-1:0] curOh;
    logic [NUM_STAGES-1:0] nxtOh;
    logic [1:0]            nxtStage;
    logic [ADDR_W-1:0]     lastAddr;
    logic                  actFlag;

    for (genvar i = 0; i < 4; i++) begin : g_in
        if (i < NUM_STAGES) begin : g_used
            assign stageIn[i] = STAGE_IN[16*i +: 16];
        end else begin : g_unused
            assign stageIn[i] = 16'd1;
        end
    end

    assign curOh    = NUM_STAGES'(1) << stage_idx;
    assign nxtOh    = curOh << 1;
    assign nxtStage = stage_idx + 2'd1;
    assign lastAddr = ADDR_W'(stageIn[stage_idx] - 16'd1);
    assign actFlag  = |(act_done & curOh);

    // Address count plus drain cycles, minus one because the entry cycle is already spent.
    function automatic logic [CNT_W-1:0] layerLoad(input logic [15:0] n);
        return CNT_W'(int'(n) + TAIL_CYC - 1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            firstCyc  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage_idx <= '0;
            w_addr    <= '0;
            w_sel     <= '0;
            layer_rst <= '1;
            act_rst   <= '1;
            cls_en    <= 1'b0;
`ifdef FC_SEQ_TIMEOUT_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LAYER;
                        busy      <= 1'b1;
                        stage_idx <= '0;
                        w_addr    <= '0;
                        w_sel     <= NUM_STAGES'(1);
                        layer_rst <= ~NUM_STAGES'(1);
                        cnt       <= layerLoad(stageIn[0]);
`ifdef FC_SEQ_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                    end
                end
                S_LAYER: begin
                    if (cnt == '0) begin
                        state    <= S_ACT;
                        firstCyc <= 1'b1;
                        w_sel    <= '0;
                        act_rst  <= act_rst & ~curOh;
                        cnt      <= TMO_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (w_addr != lastAddr) w_addr <= w_addr + ADDR_W'(1);
                    end
                end
                S_ACT: begin
                    // act_done may still be high from a previous run on the entry cycle
                    firstCyc <= 1'b0;
                    if (!firstCyc && actFlag) begin
                        if (stage_idx == LAST) begin
                            state    <= S_CLS;
                            cls_en   <= 1'b1;
                            firstCyc <= 1'b1;
                            cnt      <= TMO_LOAD;
                        end else begin
                            state     <= S_LAYER;
                            stage_idx <= nxtStage;
                            w_addr    <= '0;
                            w_sel     <= nxtOh;
                            layer_rst <= layer_rst & ~nxtOh;
                            cnt       <= layerLoad(stageIn[nxtStage]);
                        end
                    end
`ifdef FC_SEQ_TIMEOUT_EN
                    else if (cnt == '0) begin
                        state     <= S_IDLE;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        stage_idx <= '0;
                        w_addr    <= '0;
                        w_sel     <= '0;
                        layer_rst <= '1;
                        act_rst   <= '1;
                        cls_en    <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
`endif
                end
                S_CLS: begin
                    firstCyc <= 1'b0;
                    if (!firstCyc && cls_ack) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
`ifdef FC_SEQ_TIMEOUT_EN
                    else if (cnt == '0) begin
                        state     <= S_IDLE;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        stage_idx <= '0;
                        w_addr    <= '0;
                        w_sel     <= '0;
                        layer_rst <= '1;
                        act_rst   <= '1;
                        cls_en    <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
`endif
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    stage_idx <= '0;
                    w_addr    <= '0;
                    w_sel     <= '0;
                    layer_rst <= '1;
                    act_rst   <= '1;
                    cls_en    <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef FC_SEQ_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fc_chain_sequencer.sv
// Scoreboard bench for fc_chain_sequencer: a timeline model per run predicts the weight-address
// stream, the done pulse and the per-cycle control outputs; a monitor compares on the falling edge.
module tb_fc_chain_sequencer;
    localparam int NS   = 2;
    localparam int AW   = 8;
    localparam int TAIL = 3;
    localparam int TMO  = 20;
    localparam logic [16*NS-1:0] SIN = {16'd4, 16'd8};
    localparam int CW   = 4 + 3*NS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          cls_ack = 1'b0;
    logic [NS-1:0] act_done = '0;
    logic          busy, done, cls_en, err;
    logic [1:0]    stage_idx;
    logic [AW-1:0] w_addr;
    logic [NS-1:0] w_sel, layer_rst, act_rst;

    fc_chain_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .STAGE_IN(SIN), .TAIL_CYC(TAIL), .TMO_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .stage_idx(stage_idx), .w_addr(w_addr), .w_sel(w_sel), .layer_rst(layer_rst),
        .act_rst(act_rst), .act_done(act_done), .cls_en(cls_en), .cls_ack(cls_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit isDone;
        int r;
        int stage;
        int addr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   edgeCnt = 0;
    int   nIn[NS] = '{8, 4};

    // current run plan, in cycles relative to the accepting edge (cycle 1 = first cycle after it)
    bit   runValid = 1'b0;
    bit   errBefore = 1'b0;
    bit   errModel = 1'b0;
    int   runS = 0, runD = 0, c0 = 0, tmoAt = 0;
    int   lS[NS], aS[NS];

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    function automatic logic [CW-1:0] expCtl(input int r, output bit idle);
        logic [NS-1:0] lr, ar, ws;
        bit b, d, c, e;
        idle = 1'b1;
        e = 1'b0;
        if (runValid) begin
            if (r < 1) e = errBefore;
            else if (tmoAt != 0 && r >= tmoAt) e = 1'b1;
            else if (tmoAt == 0 && r > runD) e = 1'b0;
            else idle = 1'b0;
        end
        if (idle) return {3'b000, e, {NS{1'b1}}, {NS{1'b1}}, {NS{1'b0}}};
        for (int s = 0; s < NS; s++) begin
            lr[s] = !(r >= lS[s]);
            ar[s] = !(r >= aS[s]);
            ws[s] = (r >= lS[s]) && (r < aS[s]);
        end
        b = (r < runD);
        d = (r == runD);
        c = (c0 != 0) && (r >= c0);
        return {b, d, c, 1'b0, lr, ar, ws};
    endfunction

    always @(negedge clk) begin : mon
        int r;
        bit idle;
        logic [CW-1:0] e, a;
        exp_t x;
        r = edgeCnt - runS + 1;
        e = expCtl(r, idle);
        a = {busy, done, cls_en, err, layer_rst, act_rst, w_sel};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL ctl t=%0t r=%0d {busy,done,cls_en,err,layer_rst,act_rst,w_sel} got=%b want=%b",
                     $time, r, a, e);
        end
        if (idle) begin
            checks++;
            if ({stage_idx, w_addr} !== '0) begin
                errors++;
                $display("FAIL idle_addr t=%0t stage_idx=%0d w_addr=%0d want 0/0", $time, stage_idx, w_addr);
            end
        end
        if (w_sel !== '0 || done === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out t=%0t w_sel=%b done=%b w_addr=%0d", $time, w_sel, done, w_addr);
            end else begin
                x = expQ.pop_front();
                if (x.isDone != done || x.r != r || x.stage != int'(stage_idx) ||
                    (!x.isDone && x.addr != int'(w_addr))) begin
                    errors++;
                    $display("FAIL stream r=%0d got done=%b stage=%0d addr=%0d want done=%0d r=%0d stage=%0d addr=%0d",
                             r, done, stage_idx, w_addr, x.isDone, x.r, x.stage, x.addr);
                end
            end
        end
    end

    // Called at a falling edge; the start pulse is taken by the next rising edge.
    // dAs/dC: act_done/cls_ack rise this many cycles after their release (may be negative).
    task automatic doRun(input int dA0, input int dA1, input int dC, input int spur,
                         input int gap, input int rstAt);
        int dA[NS];
        int hA[NS];
        int t, hC, lastC, ad;
        dA[0] = dA0;
        dA[1] = dA1;
        runValid  = 1'b1;
        runS      = edgeCnt + 1;
        tmoAt     = 0;
        errBefore = errModel;
        errModel  = 1'b0;
        t = 1;
        for (int s = 0; s < NS; s++) begin
            lS[s] = t;
            aS[s] = t + nIn[s] + TAIL;
            hA[s] = aS[s] + dA[s];
            for (int k = 0; k < nIn[s] + TAIL; k++) begin
                ad = (k < nIn[s]) ? k : nIn[s] - 1;
                expQ.push_back('{1'b0, t + k, s, ad});
            end
            t = ((hA[s] > aS[s] + 1) ? hA[s] : aS[s] + 1) + 1;
        end
        c0    = t;
        hC    = c0 + dC;
        lastC = (hC > c0 + 1) ? hC : c0 + 1;
        runD  = lastC + 1;
        expQ.push_back('{1'b1, runD, NS - 1, 0});
        for (int r = 0; r <= runD; r++) begin
            start = (r == 0) || (r == spur);
            for (int s = 0; s < NS; s++) act_done[s] = (r >= hA[s]);
            cls_ack = (r >= hC);
            if (r == rstAt) begin
                @(posedge clk);
                #2;
                reset    = 1'b1;
                runValid = 1'b0;
                errModel = 1'b0;
                expQ.delete();
                start    = 1'b0;
                act_done = '0;
                cls_ack  = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                repeat (5) @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        act_done = '0;
        cls_ack  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

`ifdef FC_SEQ_TIMEOUT_EN
    task automatic doTmoRun();
        runValid  = 1'b1;
        runS      = edgeCnt + 1;
        errBefore = errModel;
        errModel  = 1'b1;
        lS[0] = 1;
        aS[0] = 1 + nIn[0] + TAIL;
        for (int s = 1; s < NS; s++) begin
            lS[s] = 1 << 30;
            aS[s] = 1 << 30;
        end
        c0    = 0;
        runD  = 1 << 30;
        tmoAt = aS[0] + TMO;
        for (int k = 0; k < nIn[0] + TAIL; k++)
            expQ.push_back('{1'b0, 1 + k, 0, (k < nIn[0]) ? k : nIn[0] - 1});
        act_done = '0;
        cls_ack  = 1'b0;
        for (int r = 0; r <= tmoAt + 3; r++) begin
            start = (r == 0);
            @(negedge clk);
        end
        start = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        doRun(5, 5, 5, -1, 1, -1);
        doRun(-3, 2, 1, 15, 0, -1);
        doRun(5, 5, 5, -1, 1, 5);
        doRun(5, 5, 5, 37, 0, -1);
        for (int i = 0; i < 20; i++) begin
            doRun(int'($urandom_range(0, 9)) - 3, int'($urandom_range(0, 9)) - 3,
                  int'($urandom_range(0, 8)) - 2, int'($urandom_range(1, 45)),
                  int'($urandom_range(0, 2)), -1);
        end
`ifdef FC_SEQ_TIMEOUT_EN
        doTmoRun();
        doRun(2, 3, 2, -1, 1, -1);
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d entries want=0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
